// File: rtl/vram_defs.sv
// rtl/vram_defs.sv - shared VRAM requester IDs for the arbiter and its clients
package vram_defs;

    localparam int ID_W = 2;

    localparam logic [ID_W-1:0] ID_DISP = 2'd0;
    localparam logic [ID_W-1:0] ID_CPU  = 2'd1;
    localparam logic [ID_W-1:0] ID_DMA  = 2'd2;

endpackage

// File: rtl/vram_arbiter_rr_arb2.sv
// rtl/vram_arbiter_rr_arb2.sv - two-way round-robin pick with last-winner pointer
module rr_arb2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic upd_a_i,
    input  logic upd_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    // ptr_q high means b is preferred on the next tie
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_a_o = req_a_i & (~req_b_i | ~ptr_q);
        gnt_b_o = req_b_i & (~req_a_i | ptr_q);
        ptr_d   = ptr_q;
        if (upd_a_i) begin
            ptr_d = 1'b1;
        end else if (upd_b_i) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - three-requester single-port VRAM arbiter
module vram_arbiter
    import vram_defs::*;
#(
    parameter int ADDRW      = 14,
    parameter int DATAW      = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             disp_req,
    input  logic             disp_we,
    input  logic [ADDRW-1:0] disp_addr,
    input  logic [DATAW-1:0] disp_din,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [ADDRW-1:0] cpu_addr,
    input  logic [DATAW-1:0] cpu_din,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [ADDRW-1:0] dma_addr,
    input  logic [DATAW-1:0] dma_din,
    output logic             disp_gnt,
    output logic             disp_rvalid,
    output logic [DATAW-1:0] disp_dout,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [DATAW-1:0] cpu_dout,
    output logic             dma_gnt,
    output logic             dma_rvalid,
    output logic [DATAW-1:0] dma_dout,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_din,
    input  logic [DATAW-1:0] mem_dout
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]       cpu_wait_q, cpu_wait_d, dma_wait_q, dma_wait_d;
    logic             cpu_starved, dma_starved, any_starved;
    logic             rr_gnt_a, rr_gnt_b, any_gnt;
    logic [ID_W-1:0]  sel_id;
    logic             sel_we;
    logic [ADDRW-1:0] sel_addr;
    logic [DATAW-1:0] sel_din;

    logic             mem_we_q, s1_rd_q, rd_valid_q;
    logic [ID_W-1:0]  s1_id_q, rd_id_q;
    logic [ADDRW-1:0] mem_addr_q;
    logic [DATAW-1:0] mem_din_q, disp_dout_q, cpu_dout_q, dma_dout_q;

    assign cpu_starved = cpu_req && (cpu_wait_q == STARVE_LIM);
    assign dma_starved = dma_req && (dma_wait_q == STARVE_LIM);
    assign any_starved = cpu_starved | dma_starved;

    // Starved requesters reuse the round-robin pick so a double starvation stays fair
    rr_arb2 u_rr (
        .clk_i   (clk_sys),
        .rst_i   (rst_sys),
        .req_a_i (any_starved ? cpu_starved : cpu_req),
        .req_b_i (any_starved ? dma_starved : dma_req),
        .upd_a_i (cpu_gnt),
        .upd_b_i (dma_gnt),
        .gnt_a_o (rr_gnt_a),
        .gnt_b_o (rr_gnt_b)
    );

    always_comb begin
        disp_gnt = disp_req & ~any_starved & ~rst_sys;
        cpu_gnt  = rr_gnt_a & (any_starved | ~disp_req) & ~rst_sys;
        dma_gnt  = rr_gnt_b & (any_starved | ~disp_req) & ~rst_sys;
        any_gnt  = disp_gnt | cpu_gnt | dma_gnt;

        sel_id   = ID_DISP;
        sel_we   = disp_we;
        sel_addr = disp_addr;
        sel_din  = disp_din;
        if (cpu_gnt) begin
            sel_id   = ID_CPU;
            sel_we   = cpu_we;
            sel_addr = cpu_addr;
            sel_din  = cpu_din;
        end else if (dma_gnt) begin
            sel_id   = ID_DMA;
            sel_we   = dma_we;
            sel_addr = dma_addr;
            sel_din  = dma_din;
        end

        cpu_wait_d = 8'd0;
        if (cpu_req && !cpu_gnt) begin
            cpu_wait_d = (cpu_wait_q == STARVE_LIM) ? STARVE_LIM : cpu_wait_q + 8'd1;
        end
        dma_wait_d = 8'd0;
        if (dma_req && !dma_gnt) begin
            dma_wait_d = (dma_wait_q == STARVE_LIM) ? STARVE_LIM : dma_wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            cpu_wait_q  <= 8'd0;
            dma_wait_q  <= 8'd0;
            mem_we_q    <= 1'b0;
            s1_rd_q     <= 1'b0;
            s1_id_q     <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_id_q     <= '0;
            disp_dout_q <= '0;
            cpu_dout_q  <= '0;
            dma_dout_q  <= '0;
        end else begin
            cpu_wait_q <= cpu_wait_d;
            dma_wait_q <= dma_wait_d;
            mem_we_q   <= any_gnt & sel_we;
            s1_rd_q    <= any_gnt & ~sel_we;
            s1_id_q    <= sel_id;
            if (any_gnt) begin
                mem_addr_q <= sel_addr;
                mem_din_q  <= sel_din;
            end
            rd_valid_q <= s1_rd_q;
            rd_id_q    <= s1_id_q;
            if (rd_valid_q) begin
                if (rd_id_q == ID_DISP) disp_dout_q <= mem_dout;
                if (rd_id_q == ID_CPU)  cpu_dout_q  <= mem_dout;
                if (rd_id_q == ID_DMA)  dma_dout_q  <= mem_dout;
            end
        end
    end

    // Outputs are masked by reset so they read zero from the first reset cycle
    always_comb begin
        disp_rvalid = rd_valid_q && (rd_id_q == ID_DISP) && !rst_sys;
        cpu_rvalid  = rd_valid_q && (rd_id_q == ID_CPU)  && !rst_sys;
        dma_rvalid  = rd_valid_q && (rd_id_q == ID_DMA)  && !rst_sys;
        disp_dout   = rst_sys ? '0 : (disp_rvalid ? mem_dout : disp_dout_q);
        cpu_dout    = rst_sys ? '0 : (cpu_rvalid  ? mem_dout : cpu_dout_q);
        dma_dout    = rst_sys ? '0 : (dma_rvalid  ? mem_dout : dma_dout_q);
        mem_we      = mem_we_q & ~rst_sys;
        mem_addr    = rst_sys ? '0 : mem_addr_q;
        mem_din     = rst_sys ? '0 : mem_din_q;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed vector bench for vram_arbiter
module tb_vram_arbiter;

    localparam int ADDRW = 14;
    localparam int DATAW = 16;

    logic             clk_sys = 1'b0;
    logic             rst_sys;
    logic             disp_req, disp_we, cpu_req, cpu_we, dma_req, dma_we;
    logic [ADDRW-1:0] disp_addr, cpu_addr, dma_addr, mem_addr;
    logic [DATAW-1:0] disp_din, cpu_din, dma_din, mem_din, mem_dout;
    logic             disp_gnt, cpu_gnt, dma_gnt, mem_we;
    logic             disp_rvalid, cpu_rvalid, dma_rvalid;
    logic [DATAW-1:0] disp_dout, cpu_dout, dma_dout;

    logic [DATAW-1:0] vram [0:(1<<ADDRW)-1];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       d;
        logic       c;
        logic       m;
        logic [2:0] gnt;
    } vec_t;

    vec_t tbl [25];

    vram_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW), .STARVE_MAX(4)) dut (
        .clk_sys     (clk_sys),
        .rst_sys     (rst_sys),
        .disp_req    (disp_req),
        .disp_we     (disp_we),
        .disp_addr   (disp_addr),
        .disp_din    (disp_din),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_din     (dma_din),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_dout   (disp_dout),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_dout    (cpu_dout),
        .dma_gnt     (dma_gnt),
        .dma_rvalid  (dma_rvalid),
        .dma_dout    (dma_dout),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // Single-port VRAM with one-cycle registered read
    always @(posedge clk_sys) begin
        if (mem_we) vram[mem_addr] <= mem_din;
        mem_dout <= vram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        disp_req = 0; disp_we = 0; disp_addr = '0; disp_din = '0;
        cpu_req  = 0; cpu_we  = 0; cpu_addr  = '0; cpu_din  = '0;
        dma_req  = 0; dma_we  = 0; dma_addr  = '0; dma_din  = '0;
    endtask

    // Advance to the next cycle: inputs change just after the rising edge
    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic sample();
        #4;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b000};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b010};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b001};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b010};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b001};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b010};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b100};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b100};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b100};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b100};
        tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b100};
        tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b100};
        tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b001};
        tbl[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b100};
        tbl[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000};

        vram[14'h0123] = 16'hBEEF;
        vram[14'h0010] = 16'h0000;
        vram[14'h0000] = 16'h0000;
        idle();
        rst_sys = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;

        for (int i = 0; i < 25; i++) begin
            if (i != 0) next_cycle();
            rst_sys  = tbl[i].rst;
            disp_req = tbl[i].d;
            cpu_req  = tbl[i].c;
            dma_req  = tbl[i].m;
            sample();
            chk($sformatf("gnt_row%0d", i), {29'd0, disp_gnt, cpu_gnt, dma_gnt}, {29'd0, tbl[i].gnt});
            if (tbl[i].rst) begin
                chk($sformatf("rst_mem_we_row%0d", i), {31'd0, mem_we}, 32'd0);
                chk($sformatf("rst_rvalid_row%0d", i), {29'd0, disp_rvalid, cpu_rvalid, dma_rvalid}, 32'd0);
            end
        end

        // Read latency: cpu read of preloaded word
        next_cycle();
        idle();
        rst_sys = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0123;
        sample();
        chk("rd_cpu_gnt_G", {31'd0, cpu_gnt}, 32'd1);
        next_cycle();
        idle();
        sample();
        chk("rd_mem_addr_G1", {18'd0, mem_addr}, 32'h0123);
        chk("rd_mem_we_G1", {31'd0, mem_we}, 32'd0);
        chk("rd_cpu_rvalid_G1", {31'd0, cpu_rvalid}, 32'd0);
        next_cycle();
        sample();
        chk("rd_cpu_rvalid_G2", {31'd0, cpu_rvalid}, 32'd1);
        chk("rd_cpu_dout_G2", {16'd0, cpu_dout}, 32'hBEEF);
        chk("rd_other_rvalid_G2", {30'd0, disp_rvalid, dma_rvalid}, 32'd0);
        next_cycle();
        sample();
        chk("rd_cpu_rvalid_G3", {31'd0, cpu_rvalid}, 32'd0);
        chk("rd_cpu_dout_hold_G3", {16'd0, cpu_dout}, 32'hBEEF);

        // Write then read: dma write followed immediately by disp read
        next_cycle();
        dma_req = 1; dma_we = 1; dma_addr = 14'h0010; dma_din = 16'h5A5A;
        sample();
        chk("wr_dma_gnt_G", {31'd0, dma_gnt}, 32'd1);
        next_cycle();
        idle();
        disp_req = 1; disp_we = 0; disp_addr = 14'h0010;
        sample();
        chk("wr_disp_gnt_G1", {31'd0, disp_gnt}, 32'd1);
        chk("wr_mem_we_G1", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_addr_G1", {18'd0, mem_addr}, 32'h0010);
        chk("wr_mem_din_G1", {16'd0, mem_din}, 32'h5A5A);
        next_cycle();
        idle();
        sample();
        chk("wr_mem_we_G2", {31'd0, mem_we}, 32'd0);
        chk("wr_dma_rvalid_G2", {31'd0, dma_rvalid}, 32'd0);
        next_cycle();
        sample();
        chk("wr_disp_rvalid_G3", {31'd0, disp_rvalid}, 32'd1);
        chk("wr_disp_dout_G3", {16'd0, disp_dout}, 32'h5A5A);
        chk("wr_dma_rvalid_G3", {31'd0, dma_rvalid}, 32'd0);

        // Reset mid-operation: cpu read granted, then reset the next cycle
        next_cycle();
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0123;
        sample();
        chk("mr_cpu_gnt_G", {31'd0, cpu_gnt}, 32'd1);
        next_cycle();
        idle();
        rst_sys = 1'b1;
        sample();
        chk("mr_mem_addr_rst", {18'd0, mem_addr}, 32'd0);
        chk("mr_mem_din_rst", {16'd0, mem_din}, 32'd0);
        chk("mr_mem_we_rst", {31'd0, mem_we}, 32'd0);
        chk("mr_cpu_dout_rst", {16'd0, cpu_dout}, 32'd0);
        chk("mr_disp_dout_rst", {16'd0, disp_dout}, 32'd0);
        chk("mr_rvalid_rst", {29'd0, disp_rvalid, cpu_rvalid, dma_rvalid}, 32'd0);
        next_cycle();
        rst_sys = 1'b0;
        cpu_req = 1; dma_req = 1;
        sample();
        chk("mr_cpu_rvalid_G2", {31'd0, cpu_rvalid}, 32'd0);
        chk("mr_mem_we_G2", {31'd0, mem_we}, 32'd0);
        chk("mr_tie_after_rst", {30'd0, cpu_gnt, dma_gnt}, 32'b10);
        next_cycle();
        idle();
        sample();
        chk("mr_cpu_rvalid_G3", {31'd0, cpu_rvalid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
